// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default sizing for the program loader.
package loader_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;
   localparam int DEF_D = 9;
   localparam int DEF_W = 9;
   localparam int DEF_CW = 16;
   localparam int DEF_MAX_CYC = 5000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear and enable that stops at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             sat
);
   assign sat = &q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) q <= '0;
      else q <= clr ? '0 : (en && !sat) ? q + 1'b1 : q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams host words into instruction memory with the core held in reset,
// then runs the core and reports finished or timeout.
module prog_loader
   import loader_pkg::*;
#(
   parameter int D       = DEF_D,
   parameter int W       = DEF_W,
   parameter int CW      = DEF_CW,
   parameter int MAX_CYC = DEF_MAX_CYC
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [D:0]    len,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          im_wr_en,
   output logic [D:0]    im_addr,
   output logic [W-1:0]  im_wr_data,
   output logic          core_reset,
   input  logic          core_done,
   output logic          busy,
   output logic          finished,
   output logic          timeout,
   output logic [CW-1:0] cycle_count
);
   state_t     state;
   logic [D:0] len_r, idx;
   logic       xfer, at_lim, cnt_clr, cnt_en, cnt_sat;
   assign xfer    = in_valid && in_ready;
   assign at_lim  = cycle_count == CW'(MAX_CYC - 1);
   assign cnt_clr = state == IDLE && start;
   // the cycle that sees done or hits the limit is not counted
   assign cnt_en  = state == RUN && !core_done && !at_lim && !cnt_sat;
   sat_counter #(.WIDTH(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .q     (cycle_count),
      .sat   (cnt_sat)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         len_r      <= '0;
         idx        <= '0;
         in_ready   <= 1'b0;
         im_wr_en   <= 1'b0;
         im_addr    <= '0;
         im_wr_data <= '0;
         core_reset <= 1'b1;
         busy       <= 1'b0;
         finished   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         im_wr_en <= xfer;
         if (xfer) begin
            im_addr    <= idx;
            im_wr_data <= in_data;
            idx        <= idx + 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               len_r    <= len;
               idx      <= '0;
               busy     <= 1'b1;
               finished <= 1'b0;
               timeout  <= 1'b0;
               in_ready <= len != '0;
               state    <= (len != '0) ? LOAD : ARM;
            end
            LOAD: if (xfer && idx == len_r - 1'b1) begin
               in_ready <= 1'b0;
               state    <= ARM;
            end
            ARM: begin
               core_reset <= 1'b0;
               state      <= RUN;
            end
            RUN: if (core_done || at_lim) begin
               finished   <= core_done;
               timeout    <= !core_done;
               core_reset <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven and randomized load+run sequences checked against a behavioural model.
module tb_prog_loader;
   localparam int D = 9, W = 9, CW = 16, MAX = 20;
   typedef struct {
      int         len;
      logic [7:0] vpat;
      int         plen;
      int         k;
      bit         dload;
      int         start_at;
      bit         fix;
      bit         exp_fin;
      bit         exp_to;
      int         exp_cnt;
   } vec_t;
   logic clk = 0, reset = 0, start = 0, in_valid = 0, core_done = 0;
   logic [D:0] len = '0;
   logic [W-1:0] in_data = '0;
   logic in_ready, im_wr_en, core_reset, busy, finished, timeout;
   logic [D:0] im_addr;
   logic [W-1:0] im_wr_data;
   logic [CW-1:0] cycle_count;
   int n_chk = 0, n_fail = 0, cyc = 0;
   int wr_a[$], wr_d[$], wr_t[$];
   logic [W-1:0] words[0:15];
   vec_t tbl[7];

   prog_loader #(.D(D), .W(W), .CW(CW), .MAX_CYC(MAX)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wr_data(im_wr_data),
      .core_reset(core_reset), .core_done(core_done), .busy(busy),
      .finished(finished), .timeout(timeout), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (im_wr_en) begin
      wr_a.push_back(int'(im_addr));
      wr_d.push_back(int'(im_wr_data));
      wr_t.push_back(cyc);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_wr_en"}, im_wr_en, 0);
      chk({tag, "_addr"}, im_addr, 0);
      chk({tag, "_wdata"}, im_wr_data, 0);
      chk({tag, "_core_reset"}, core_reset, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_finished"}, finished, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_cycle_count"}, cycle_count, 0);
   endtask

   task automatic feed(input int n, input logic [7:0] vpat, input int plen, input bit dload, output int got);
      int c = 0;
      logic r;
      got = 0;
      while (got < n && c < 200) begin
         in_valid  = vpat[c % plen];
         in_data   = words[got];
         core_done = dload;
         r = in_ready;
         @(negedge clk);
         if (r && in_valid) got++;
         c++;
      end
   endtask

   task automatic do_seq(input vec_t v);
      int got, c, seen, arm_w, rdy_run, n;
      for (int i = 0; i < 16; i++) words[i] = W'($urandom);
      if (v.fix) begin
         words[0] = 9'h1A3; words[1] = 9'h055; words[2] = 9'h100;
      end
      wr_a.delete(); wr_d.delete(); wr_t.delete();
      start = 1; len = D'(v.len) + 1'b0;
      @(negedge clk);
      start = 0;
      chk("start_busy", busy, 1);
      chk("start_fin", finished, 0);
      chk("start_to", timeout, 0);
      chk("start_cnt", cycle_count, 0);
      feed(v.len, v.vpat, v.plen, v.dload, got);
      in_valid = 1; in_data = '1; core_done = 0;
      chk("load_words", got, v.len);
      chk("load_nofin", finished, 0);
      chk("arm_core_reset", core_reset, 1);
      chk("arm_in_ready", in_ready, 0);
      seen = 0; arm_w = 0; rdy_run = 0; c = 0;
      while (busy && c < 60) begin
         if (core_reset) begin
            if (seen == 0) arm_w++;
            core_done = 0; start = 0;
         end else begin
            core_done = (seen == v.k);
            start = (seen == v.start_at);
            len = 7;
            rdy_run += int'(in_ready);
            seen++;
         end
         @(negedge clk);
         c++;
      end
      core_done = 0; start = 0; in_valid = 0;
      chk("arm_cycles", arm_w, 1);
      chk("run_in_ready", rdy_run, 0);
      chk("end_busy", busy, 0);
      chk("end_finished", finished, v.exp_fin);
      chk("end_timeout", timeout, v.exp_to);
      chk("end_cycle_count", cycle_count, v.exp_cnt);
      chk("end_core_reset", core_reset, 1);
      chk("wr_count", wr_a.size(), v.len);
      n = wr_a.size() < v.len ? wr_a.size() : v.len;
      for (int i = 0; i < n; i++) begin
         chk("wr_addr", wr_a[i], i);
         chk("wr_data", wr_d[i], words[i]);
         if (v.plen == 1 && v.vpat[0]) chk("wr_b2b", wr_t[i] - wr_t[0], i);
      end
   endtask

   initial begin
      int got;
      vec_t v;
      tbl[0] = '{3, 8'hFF, 1, 4, 0, -1, 1, 1, 0, 4};
      tbl[1] = '{3, 8'h19, 5, 6, 0, -1, 0, 1, 0, 6};
      tbl[2] = '{0, 8'hFF, 1, 10, 0, -1, 0, 1, 0, 10};
      tbl[3] = '{2, 8'hFF, 1, 100, 0, -1, 0, 0, 1, 19};
      tbl[4] = '{3, 8'h5B, 8, 5, 1, 2, 0, 1, 0, 5};
      tbl[5] = '{1, 8'hFF, 1, 19, 0, -1, 0, 1, 0, 19};
      tbl[6] = '{0, 8'hFF, 1, 0, 0, -1, 0, 1, 0, 0};
      repeat (2) @(negedge clk);
      chk_reset_vals("por");
      reset = 1;
      @(negedge clk);
      foreach (tbl[i]) do_seq(tbl[i]);
      for (int i = 0; i < 5; i++) words[i] = W'(9'h0A1 + i);
      start = 1; len = 5;
      @(negedge clk);
      start = 0;
      feed(2, 8'hFF, 1, 0, got);
      chk("mid_load_words", got, 2);
      #1 reset = 0;
      #1 chk_reset_vals("async");
      @(negedge clk);
      chk_reset_vals("held");
      reset = 1; in_valid = 0;
      @(negedge clk);
      v = '{2, 8'hFF, 1, 3, 0, -1, 0, 1, 0, 3};
      do_seq(v);
      for (int r = 0; r < 25; r++) begin
         v.len = $urandom_range(0, 6);
         v.vpat = 8'($urandom) | 8'h01;
         v.plen = 8;
         v.k = $urandom_range(0, 25);
         v.dload = 1'($urandom);
         v.start_at = $urandom_range(0, 3) == 0 ? -1 : $urandom_range(0, 15);
         v.fix = 0;
         v.exp_fin = v.k <= MAX - 1;
         v.exp_to = !v.exp_fin;
         v.exp_cnt = v.exp_fin ? v.k : MAX - 1;
         do_seq(v);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
